// File: rtl/a3_pkg.sv
// a3_pkg: shared constants for the A3 processing-element controllers.
// Holds the PE mode (ber) encodings, the sequencer state encoding and the default width.
package a3_pkg;

  localparam int A3_DW = 32;

  localparam logic [1:0] MODE_FB   = 2'b00;
  localparam logic [1:0] MODE_FF   = 2'b01;
  localparam logic [1:0] MODE_EMIT = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FB   = 3'd2,
    FF   = 3'd3,
    EMIT = 3'd4
  } a3_state_e;

  // PE mode driven while the sequencer sits in a given state.
  function automatic logic [1:0] ber_for_state(input a3_state_e st);
    logic [1:0] ber;
    case (st)
      FB:      ber = MODE_FB;
      FF:      ber = MODE_FF;
      EMIT:    ber = MODE_EMIT;
      default: ber = MODE_LOAD;
    endcase
    return ber;
  endfunction

endpackage

// File: rtl/a3_phase_cnt.sv
// a3_phase_cnt: phase timer counting 0..PH_CYC-1 with synchronous clear.
// `last` flags the final cycle of a phase. Reused by other A3 controllers.
module a3_phase_cnt #(
  parameter int PH_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);

  localparam int CW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PH_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == CNT_LAST);

  // Next count: wrap after the last phase cycle, or restart on a state change.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || last) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/a3_seq.sv
// a3_seq: sequencer and stream front-end for the A3 filter PE.
// Accepts a sample, walks the PE through LOAD/FB/FF/EMIT (PH_CYC cycles each),
// then captures the PE result onto an output valid/ready stream.
// Optional feature: define A3_SEQ_CNT_EN to add the `sample_cnt` handshake counter.
//
// state | meaning
// IDLE  | waiting for a sample, PE held in load mode with zero input
// LOAD  | latched sample presented on pe_in
// FB    | PE feedback phase
// FF    | PE feed-forward phase
// EMIT  | PE result valid; captured on the last cycle
module a3_seq
  import a3_pkg::*;
#(
  parameter int DW     = A3_DW,
  parameter int PH_CYC = 3       // >= 3 to cover the PE mul1/mul2/add pipeline
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_in_data,
  input  logic          s_in_valid,
  output logic          s_in_ready,
  output logic [DW-1:0] pe_in,
  output logic [1:0]    pe_ber,
  input  logic [DW-1:0] pe_out,
  output logic [DW-1:0] m_out_data,
  output logic          m_out_valid,
  input  logic          m_out_ready,
  output logic          busy
`ifdef A3_SEQ_CNT_EN
  ,
  output logic [31:0]   sample_cnt
`endif
);

  a3_state_e     state_q, state_d;
  logic [DW-1:0] sample_q, sample_d;
  logic [DW-1:0] pe_in_q, pe_in_d;
  logic [1:0]    pe_ber_q, pe_ber_d;
  logic [DW-1:0] m_out_data_q, m_out_data_d;
  logic          m_out_valid_q, m_out_valid_d;
  logic          busy_q, busy_d;
  logic          ph_last;
  logic          accept;
  logic          capture;
  logic          pop;

  // The output register is always empty or draining when a sample is accepted,
  // so the capture at the end of EMIT can never overwrite an unread result.
  assign s_in_ready = (state_q == IDLE) && (!m_out_valid_q || m_out_ready);
  assign accept     = s_in_valid && s_in_ready;
  assign capture    = (state_q == EMIT) && ph_last;
  assign pop        = m_out_valid_q && m_out_ready;

  a3_phase_cnt #(
    .PH_CYC (PH_CYC)
  ) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .last (ph_last)
  );

  // Next state, sample latch, output capture and the registered PE drives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = LOAD;
      LOAD:    if (ph_last) state_d = FB;
      FB:      if (ph_last) state_d = FF;
      FF:      if (ph_last) state_d = EMIT;
      EMIT:    if (ph_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sample_d = accept ? s_in_data : sample_q;

    // A capture takes priority over a pop in the same cycle.
    m_out_data_d  = capture ? pe_out : m_out_data_q;
    m_out_valid_d = m_out_valid_q;
    if (capture) begin
      m_out_valid_d = 1'b1;
    end else if (pop) begin
      m_out_valid_d = 1'b0;
    end

    pe_ber_d = ber_for_state(state_d);
    pe_in_d  = (state_d == LOAD) ? sample_d : '0;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sample_q      <= '0;
      pe_in_q       <= '0;
      pe_ber_q      <= MODE_LOAD;
      m_out_data_q  <= '0;
      m_out_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      pe_in_q       <= pe_in_d;
      pe_ber_q      <= pe_ber_d;
      m_out_data_q  <= m_out_data_d;
      m_out_valid_q <= m_out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign pe_in       = pe_in_q;
  assign pe_ber      = pe_ber_q;
  assign m_out_data  = m_out_data_q;
  assign m_out_valid = m_out_valid_q;
  assign busy        = busy_q;

`ifdef A3_SEQ_CNT_EN
  logic [31:0] sample_cnt_q, sample_cnt_d;

  // Output handshake count; wraps naturally at 32 bits.
  always_comb begin
    sample_cnt_d = pop ? sample_cnt_q + 32'd1 : sample_cnt_q;
  end

  // Handshake counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_a3_seq.sv
// tb_a3_seq: randomized self-checking bench for a3_seq against a
// transaction-level model (cycles elapsed since accept -> expected drives).
module tb_a3_seq;

  localparam int DW    = 32;
  localparam int PH    = 3;
  localparam int SCHED = 4 * PH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_in_data = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [DW-1:0] pe_in;
  logic [1:0]    pe_ber;
  logic [DW-1:0] pe_out = '0;
  logic [DW-1:0] m_out_data;
  logic          m_out_valid;
  logic          m_out_ready = 1'b0;
  logic          busy;
`ifdef A3_SEQ_CNT_EN
  logic [31:0]   sample_cnt;
`endif

  a3_seq #(.DW(DW), .PH_CYC(PH)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in_data   (s_in_data),
    .s_in_valid  (s_in_valid),
    .s_in_ready  (s_in_ready),
    .pe_in       (pe_in),
    .pe_ber      (pe_ber),
    .pe_out      (pe_out),
    .m_out_data  (m_out_data),
    .m_out_valid (m_out_valid),
    .m_out_ready (m_out_ready),
    .busy        (busy)
`ifdef A3_SEQ_CNT_EN
    ,
    .sample_cnt  (sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: age = cycles since the accepting edge (-1 when idle).
  int          age      = -1;
  logic [31:0] m_sample = '0;
  logic [31:0] m_data   = '0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_cnt    = '0;
  bit          preload_req = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_ber();
    logic [1:0] b;
    if (age < 0) b = 2'b11;
    else begin
      case (age / PH)
        0:       b = 2'b11;
        1:       b = 2'b00;
        2:       b = 2'b01;
        default: b = 2'b10;
      endcase
    end
    return b;
  endfunction

  task automatic check_outputs();
    check_val("pe_ber", {30'b0, pe_ber}, {30'b0, exp_ber()});
    check_val("pe_in", pe_in, (age >= 0 && age < PH) ? m_sample : 32'h0);
    check_val("busy", {31'b0, busy}, {31'b0, (age >= 0)});
    check_val("m_out_valid", {31'b0, m_out_valid}, {31'b0, m_valid});
    check_val("m_out_data", m_out_data, m_data);
    check_val("s_in_ready", {31'b0, s_in_ready}, {31'b0, (age < 0) && (!m_valid || m_out_ready)});
`ifdef A3_SEQ_CNT_EN
    check_val("sample_cnt", sample_cnt, m_cnt);
`endif
  endtask

  task automatic model_reset();
    age      = -1;
    m_sample = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // to what the next rising edge should produce.
  task automatic step(input logic v, input logic [31:0] d, input logic r, output logic acc);
    logic pop, cap;
    @(negedge clk);
`ifdef A3_SEQ_CNT_EN
    if (preload_req) begin
      force dut.sample_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.sample_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      preload_req = 1'b0;
    end
`endif
    s_in_valid  = v;
    s_in_data   = d;
    m_out_ready = r;
    pe_out      = $urandom();
    #1;
    check_outputs();
    acc = (age < 0) && (!m_valid || r) && v;
    pop = m_valid && r;
    cap = (age == SCHED - 1);
    if (pop) m_cnt = m_cnt + 32'd1;
    if (cap) begin
      m_valid = 1'b1;
      m_data  = pe_out;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    if (acc) begin
      age      = 0;
      m_sample = d;
    end else if (age >= 0) begin
      age = cap ? -1 : age + 1;
    end
  endtask

  task automatic idle_steps(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, r, a);
  endtask

  initial begin
    logic a;
    int   k;
    int   guard;

    // Reset state
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single sample 0x00010000, result captured and later popped
    step(1'b1, 32'h0001_0000, 1'b0, a);
    check_val("first_accept", {31'b0, a}, 32'd1);
    idle_steps(15, 1'b0);
    check_val("result_pending", {31'b0, m_out_valid}, 32'd1);

    // Backpressure: a held result blocks new samples
    for (int i = 0; i < 8; i++) step(1'b1, 32'hDEAD_0000 + i, 1'b0, a);
    check_val("bp_busy", {31'b0, busy}, 32'd0);
    step(1'b1, 32'h0000_BEEF, 1'b1, a);
    check_val("bp_release_accept", {31'b0, a}, 32'd1);
    idle_steps(SCHED + 2, 1'b1);

    // Back-to-back samples 1, 2, 3 with output drained immediately
    k = 0;
    for (int i = 0; i < 3 * (SCHED + 1) + 3; i++) begin
      step(k < 3, k + 1, 1'b1, a);
      if (a) k++;
    end
    check_val("b2b_count", k, 3);

    // Asynchronous reset during the FF phase
    step(1'b1, 32'h1234_5678, 1'b1, a);
    guard = 0;
    while (age != 2 * PH + 1 && guard < 40) begin
      step(1'b0, 32'h0, 1'b1, a);
      guard++;
    end
    check_val("reach_ff", {30'b0, pe_ber}, 32'd1);
    @(negedge clk);
    s_in_valid  = 1'b0;
    m_out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'hCAFE_F00D, 1'b0, a);
    check_val("post_reset_accept", {31'b0, a}, 32'd1);
    idle_steps(SCHED + 3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) != 0, a);
    end
    idle_steps(SCHED + 3, 1'b1);

`ifdef A3_SEQ_CNT_EN
    // Handshake counter wrap
    step(1'b1, 32'h0000_0042, 1'b0, a);
    idle_steps(SCHED + 2, 1'b0);
    preload_req = 1'b1;
    step(1'b0, 32'h0, 1'b1, a);
    idle_steps(2, 1'b1);
    check_val("cnt_wrap", sample_cnt, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
